// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the multiplexed hex seven-segment display
package seg7_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for nibble n (listed F down to 0).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg_decode.sv
// rtl/hex7seg_decode.sv - combinational nibble to active-low segment decoder
module hex7seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_hex.sv
// rtl/seg7_scan_hex.sv - eight-digit hex scanner with per-frame snapshot and zero blanking
module seg7_scan_hex
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value,
    input  logic        blank_lz,
    input  logic        en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           snap;
    logic                  primed;
    logic                  load_q;
    logic                  tick;
    logic                  load;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_seg;
    logic                  digit_dark;

    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));
    // Snapshot only at the frame wrap so a frame never mixes two values.
    assign load = !primed || (tick && (idx == IDX_W'(NUM_DIGITS - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
            snap    <= '0;
            primed  <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                idx <= idx + 1'b1;
            end
            if (load) begin
                snap <= value;
            end
            primed <= 1'b1;
            load_q <= load;
        end
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        logic nz_above;
        blank_mask = '0;
        nz_above   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            nz_above      = nz_above | (|snap[4*i +: 4]);
            blank_mask[i] = blank_lz & ~nz_above;
        end
    end

    assign cur_nibble = snap[{idx, 2'b00} +: 4];
    assign digit_dark = blank_mask[idx] | ~en;

    hex7seg_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // frame_done trails the snapshot by one cycle so it lines up with digit 0 on the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            an         <= digit_dark ? AN_OFF : ~(NUM_DIGITS'(1) << idx);
            seg        <= digit_dark ? SEG_OFF : cur_seg;
            frame_done <= load_q;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seg7_scan_hex.sv
// tb/tb_seg7_scan_hex.sv - directed self-checking bench for seg7_scan_hex
module tb_seg7_scan_hex;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] value = '0;
    logic        blank_lz = 1'b0;
    logic        en = 1'b1;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int e = 0;

    // Glyphs for 32'h12345678, digit 0 first.
    logic [6:0] full_seg [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

    seg7_scan_hex #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .blank_lz   (blank_lz),
        .en         (en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        e++;
    endtask

    task automatic start(input logic [31:0] v, input logic blz, input logic ena);
        @(negedge clk);
        rst_n    = 1'b0;
        value    = v;
        blank_lz = blz;
        en       = ena;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e = 0;
    endtask

    function automatic int slot_of(input int edge_n);
        return ((edge_n - 1) / 4) % 8;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({an, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: an=%h seg=%h dp=%b fd=%b, want FF 7F 1 0", an, seg, dp, frame_done);
        end
        rst_n = 1'b1;
        e = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (frame_done !== (e == 2)) begin
                errors++;
                $display("FAIL reset_fd edge %0d: fd=%b want %b", e, frame_done, (e == 2));
            end
        end
    endtask

    task automatic test_full_scan();
        logic [7:0] want_an;
        logic       want_fd;
        start(32'h12345678, 1'b0, 1'b1);
        step();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL scan_fd_edge1: fd=%b want 0", frame_done);
        end
        for (int k = 2; k <= 70; k++) begin
            step();
            want_an = ~(8'h01 << slot_of(e));
            want_fd = (e == 2) || (e == 33) || (e == 65);
            checks++;
            if (an !== want_an || seg !== full_seg[slot_of(e)] || frame_done !== want_fd || dp !== 1'b1) begin
                errors++;
                $display("FAIL full_scan edge %0d: an=%h seg=%h fd=%b dp=%b, want %h %h %b 1",
                         e, an, seg, frame_done, dp, want_an, full_seg[slot_of(e)], want_fd);
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [7:0] want_an;
        logic [6:0] want_seg;
        start(32'h000000A5, 1'b1, 1'b1);
        step();
        for (int k = 2; k <= 33; k++) begin
            step();
            case (slot_of(e))
                0:       begin want_an = 8'hFE; want_seg = 7'h12; end
                1:       begin want_an = 8'hFD; want_seg = 7'h08; end
                default: begin want_an = 8'hFF; want_seg = 7'h7F; end
            endcase
            checks++;
            if (an !== want_an || seg !== want_seg) begin
                errors++;
                $display("FAIL blank_lz edge %0d: an=%h seg=%h, want %h %h", e, an, seg, want_an, want_seg);
            end
        end
    endtask

    task automatic test_zero();
        start(32'h0, 1'b1, 1'b1);
        step();
        for (int k = 2; k <= 33; k++) begin
            step();
            checks++;
            if (slot_of(e) == 0 ? (an !== 8'hFE || seg !== 7'h40) : (an !== 8'hFF || seg !== 7'h7F)) begin
                errors++;
                $display("FAIL zero edge %0d: an=%h seg=%h slot %0d", e, an, seg, slot_of(e));
            end
        end
    endtask

    task automatic test_anti_tear();
        logic [6:0] want_seg;
        start(32'h11111111, 1'b0, 1'b1);
        for (int k = 1; k <= 14; k++) step();
        value = 32'h22222222;
        for (int k = 15; k <= 66; k++) begin
            if (e == 63) value = 32'h33333333;
            step();
            want_seg = (e <= 32) ? 7'h79 : (e <= 64) ? 7'h24 : 7'h30;
            checks++;
            if (seg !== want_seg || an !== ~(8'h01 << slot_of(e))) begin
                errors++;
                $display("FAIL anti_tear edge %0d: seg=%h an=%h, want seg %h", e, seg, an, want_seg);
            end
            if (e == 33 || e == 65) begin
                checks++;
                if (frame_done !== 1'b1) begin
                    errors++;
                    $display("FAIL anti_tear_fd edge %0d: fd=%b want 1", e, frame_done);
                end
            end
        end
    endtask

    task automatic test_enable_reset();
        start(32'h12345678, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++) step();
        checks++;
        if (an !== 8'hFB || seg !== 7'h02) begin
            errors++;
            $display("FAIL en_before: an=%h seg=%h want FB 02", an, seg);
        end
        en = 1'b0;
        for (int k = 10; k <= 17; k++) begin
            step();
            checks++;
            if (an !== 8'hFF || seg !== 7'h7F) begin
                errors++;
                $display("FAIL en_dark edge %0d: an=%h seg=%h want FF 7F", e, an, seg);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (an !== 8'hEF || seg !== 7'h19) begin
            errors++;
            $display("FAIL en_resume: an=%h seg=%h want EF 19", an, seg);
        end
        step();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({an, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: an=%h seg=%h dp=%b fd=%b want FF 7F 1 0", an, seg, dp, frame_done);
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_blank_lz();
        test_zero();
        test_anti_tear();
        test_enable_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
